// File: rtl/cnna_pkg.sv
// Shared definitions for the ibuf read/drain engine.
// FSM encodings and skid buffer depth.
package cnna_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2
  } rd_state_e;

  localparam int SKID_DEPTH = 2;

endpackage

// File: rtl/ibuf_rd_stream_if.sv
// Valid/ready stream bundle from the ibuf reader to the main process.
// Master drives data/valid/last, slave drives ready.
interface ibuf_rd_stream_if #(
  parameter int DSIZE = 32
);
  logic [DSIZE-1:0] data;
  logic             valid;
  logic             ready;
  logic             last;

  modport master (
    output data, valid, last,
    input  ready
  );

  modport slave (
    input  data, valid, last,
    output ready
  );
endinterface

// File: rtl/ibuf_rd_stream_skid_fifo.sv
// Two-entry skid FIFO holding {last, data} words behind the RAM.
// Overflow is prevented upstream by the read credit check.
module ibuf_skid_fifo
  import cnna_pkg::*;
#(
  parameter int W = 33
) (
  input  logic         I_clk,
  input  logic         I_rst_n,
  input  logic         I_push,
  input  logic         I_pop,
  input  logic [W-1:0] I_data,
  output logic [W-1:0] O_data,
  output logic [1:0]   O_occ
);

  logic [W-1:0] mem [SKID_DEPTH];
  logic         wp_q;
  logic         rp_q;
  logic [1:0]   occ_q;

  always_ff @(posedge I_clk) begin
    if (I_push) mem[wp_q] <= I_data;
  end

  always_ff @(posedge I_clk or negedge I_rst_n) begin
    if (!I_rst_n) begin
      wp_q  <= 1'b0;
      rp_q  <= 1'b0;
      occ_q <= 2'd0;
    end else begin
      if (I_push) wp_q <= ~wp_q;
      if (I_pop)  rp_q <= ~rp_q;
      occ_q <= occ_q + {1'b0, I_push} - {1'b0, I_pop};
    end
  end

  assign O_data = mem[rp_q];
  assign O_occ  = occ_q;

endmodule

// File: rtl/ibuf_rd_stream.sv
// Sequential reader for the ibuf spram, streaming words out via valid/ready.
// Define IBUF_RD_STALL_CNT_EN to enable the backpressure stall counter.
module ibuf_rd_stream
  import cnna_pkg::*;
#(
  parameter int ASIZE = 10,
  parameter int DSIZE = 32
) (
  input  logic             I_clk,
  input  logic             I_rst_n,
  input  logic             I_start,
  input  logic [ASIZE-1:0] I_base_addr,
  input  logic [ASIZE:0]   I_len,
  output logic             O_busy,
  output logic             O_done,
  output logic [ASIZE-1:0] O_ram_addr,
  output logic             O_ram_wr,
  input  logic [DSIZE-1:0] I_ram_data,
  ibuf_rd_stream_if.master strm,
  output logic [31:0]      O_stall_cnt
);

  localparam logic [ASIZE:0] ONE_L = 1;

  rd_state_e        state_q, state_d;
  logic [ASIZE:0]   len_q;
  logic [ASIZE:0]   issued_q;
  logic [ASIZE-1:0] addr_q;
  logic             v_q, v_last_q;
  logic             r_q, r_last_q;
  logic             zdone_q;

  logic             accept, issue, zstart, drain_done;
  logic             last_iss, credit_ok;
  logic             byp, xfer, push, pop;
  logic [1:0]       occ;
  logic [DSIZE:0]   head;
  logic [2:0]       load;

  ibuf_skid_fifo #(.W(DSIZE + 1)) u_skid (
    .I_clk  (I_clk),
    .I_rst_n(I_rst_n),
    .I_push (push),
    .I_pop  (pop),
    .I_data ({r_last_q, I_ram_data}),
    .O_data (head),
    .O_occ  (occ)
  );

  // Empty buffer: the RAM output word is presented directly.
  assign byp        = (occ == 2'd0);
  assign strm.valid = !byp || r_q;
  assign strm.data  = byp ? (r_q ? I_ram_data : '0) : head[DSIZE-1:0];
  assign strm.last  = byp ? r_last_q : head[DSIZE];
  assign xfer       = strm.valid && strm.ready;
  assign pop        = xfer && !byp;
  assign push       = r_q && !(byp && strm.ready);

  // Words held or still coming, net of the beat leaving this cycle.
  assign load = {1'b0, occ} + {2'b0, v_q} + {2'b0, r_q} - {2'b0, xfer};
  assign credit_ok = (load < 3'd2);

  always_comb begin
    state_d    = state_q;
    accept     = 1'b0;
    issue      = 1'b0;
    zstart     = 1'b0;
    drain_done = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (I_start) begin
          if (I_len != '0) begin
            accept  = 1'b1;
            issue   = 1'b1;
            state_d = ST_RUN;
          end else begin
            zstart = 1'b1;
          end
        end
      end
      ST_RUN: begin
        if (issued_q == len_q) state_d = ST_DRAIN;
        else if (credit_ok)    issue   = 1'b1;
      end
      ST_DRAIN: begin
        if (byp && !v_q && !r_q) begin
          drain_done = 1'b1;
          state_d    = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign last_iss = accept ? (I_len == ONE_L)
                           : (issued_q + ONE_L == len_q);

  always_ff @(posedge I_clk or negedge I_rst_n) begin
    if (!I_rst_n) begin
      state_q  <= ST_IDLE;
      len_q    <= '0;
      issued_q <= '0;
      addr_q   <= '0;
      v_q      <= 1'b0;
      v_last_q <= 1'b0;
      r_q      <= 1'b0;
      r_last_q <= 1'b0;
      zdone_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      zdone_q  <= zstart;
      v_q      <= issue;
      v_last_q <= issue && last_iss;
      r_q      <= v_q;
      r_last_q <= v_last_q;
      if (accept) begin
        len_q    <= I_len;
        issued_q <= ONE_L;
        addr_q   <= I_base_addr;
      end else if (issue) begin
        issued_q <= issued_q + ONE_L;
        addr_q   <= addr_q + ASIZE'(1);
      end
    end
  end

  assign O_busy     = (state_q != ST_IDLE);
  assign O_done     = drain_done || zdone_q;
  assign O_ram_addr = addr_q;
  assign O_ram_wr   = 1'b0;

`ifdef IBUF_RD_STALL_CNT_EN
  logic [31:0] stall_q;

  always_ff @(posedge I_clk or negedge I_rst_n) begin
    if (!I_rst_n) begin
      stall_q <= '0;
    end else if (accept) begin
      stall_q <= '0;
    end else if (strm.valid && !strm.ready && (stall_q != '1)) begin
      stall_q <= stall_q + 32'd1;
    end
  end

  assign O_stall_cnt = stall_q;
`else
  assign O_stall_cnt = '0;
`endif

endmodule

// File: tb/tb_ibuf_rd_stream.sv
// Bench for ibuf_rd_stream: spram model with mem[i]=i, stream
// compared beat by beat against a queue of expected words.
module tb_ibuf_rd_stream;

  localparam int ASIZE = 10;
  localparam int DSIZE = 32;
  localparam int DEPTH = 1 << ASIZE;

  logic             I_clk = 1'b0;
  logic             I_rst_n = 1'b0;
  logic             I_start = 1'b0;
  logic [ASIZE-1:0] I_base_addr = '0;
  logic [ASIZE:0]   I_len = '0;
  logic             O_busy, O_done, O_ram_wr;
  logic [ASIZE-1:0] O_ram_addr;
  logic [DSIZE-1:0] I_ram_data;
  logic [31:0]      O_stall_cnt;

  ibuf_rd_stream_if #(.DSIZE(DSIZE)) strm ();

  ibuf_rd_stream #(.ASIZE(ASIZE), .DSIZE(DSIZE)) dut (
    .I_clk      (I_clk),
    .I_rst_n    (I_rst_n),
    .I_start    (I_start),
    .I_base_addr(I_base_addr),
    .I_len      (I_len),
    .O_busy     (O_busy),
    .O_done     (O_done),
    .O_ram_addr (O_ram_addr),
    .O_ram_wr   (O_ram_wr),
    .I_ram_data (I_ram_data),
    .strm       (strm),
    .O_stall_cnt(O_stall_cnt)
  );

  always #5 I_clk = ~I_clk;

  logic [DSIZE-1:0] mem [DEPTH];
  always @(posedge I_clk) I_ram_data <= mem[O_ram_addr];

  int errors = 0;
  int checks = 0;

  logic [32:0] expq [$];
  int   cyc, done_cyc, first_v, last_cyc, beats, done_cnt, stall_obs, max_off;
  bit   busy_seen, wr_seen, prev_stall;
  logic [32:0] prev_beat;

  task automatic check(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic rdy_for(input int mode, input int k);
    case (mode)
      0:       return 1'b1;
      1:       return (k % 2) == 0;
      2:       return $urandom_range(0, 3) != 0;
      default: return k > 10;
    endcase
  endfunction

  task automatic tick(input logic rdy, input logic st,
                      input logic [ASIZE-1:0] b, input logic [ASIZE:0] l);
    logic [32:0] beat, exp;
    @(negedge I_clk);
    strm.ready  = rdy;
    I_start     = st;
    I_base_addr = b;
    I_len       = l;
    #1;
    cyc++;
    beat = {strm.last, strm.data};
    if (O_busy)   busy_seen = 1;
    if (O_ram_wr) wr_seen = 1;
    if (O_done) begin
      done_cnt++;
      if (done_cyc < 0) done_cyc = cyc;
    end
    if (strm.valid && first_v < 0) first_v = cyc;
    if (prev_stall) begin
      check("hold_valid", 64'(strm.valid), 64'd1);
      check("hold_beat", 64'(beat), 64'(prev_beat));
    end
    if (strm.valid && strm.ready) begin
      beats++;
      if (strm.last) last_cyc = cyc;
      if (expq.size() == 0) begin
        check("extra_beat", 64'(expq.size()), 64'd1);
      end else begin
        exp = expq.pop_front();
        check("beat", 64'(beat), 64'(exp));
      end
    end
    if (strm.valid && !strm.ready) stall_obs++;
    prev_stall = strm.valid && !strm.ready;
    prev_beat  = beat;
  endtask

  task automatic clear_stats();
    cyc = -1; done_cyc = -1; first_v = -1; last_cyc = -1;
    beats = 0; done_cnt = 0; stall_obs = 0; max_off = 0;
    busy_seen = 0; prev_stall = 0;
  endtask

  task automatic load_expect(input logic [ASIZE-1:0] b,
                             input logic [ASIZE:0] l);
    expq.delete();
    for (int i = 0; i < int'(l); i++)
      expq.push_back({(i == int'(l) - 1), DSIZE'((int'(b) + i) % DEPTH)});
  endtask

  task automatic run_job(input logic [ASIZE-1:0] b, input logic [ASIZE:0] l,
                         input int mode, input bit inj);
    int k, off;
    load_expect(b, l);
    clear_stats();
    tick(rdy_for(mode, 0), 1'b1, b, l);
    k = 1;
    while (done_cyc < 0 && k < 400) begin
      tick(rdy_for(mode, k), inj && (k == 3), ~b, l);
      if (mode == 3 && k <= 10) begin
        off = int'(O_ram_addr - b);
        if (off > max_off) max_off = off;
      end
      k++;
    end
    if (done_cyc < 0) check("done_timeout", 64'(done_cyc), 64'd0);
    repeat (3) tick(1'b1, 1'b0, b, l);
  endtask

  task automatic post_job(input int l, input bit do_stall);
    check("beats", 64'(beats), 64'(l));
    check("leftover", 64'(expq.size()), 64'd0);
    check("done_cnt", 64'(done_cnt), 64'd1);
`ifdef IBUF_RD_STALL_CNT_EN
    if (do_stall) check("stall_cnt", 64'(O_stall_cnt), 64'(stall_obs));
`else
    if (do_stall) check("stall_cnt", 64'(O_stall_cnt), 64'd0);
`endif
  endtask

  initial begin
    logic [ASIZE-1:0] rb;
    logic [ASIZE:0]   rl;
    for (int i = 0; i < DEPTH; i++) mem[i] = DSIZE'(i);
    strm.ready = 1'b0;
    wr_seen = 0;
    clear_stats();

    repeat (3) @(negedge I_clk);
    #1;
    check("rst_valid", 64'(strm.valid), 64'd0);
    check("rst_data", 64'(strm.data), 64'd0);
    check("rst_last", 64'(strm.last), 64'd0);
    check("rst_busy", 64'(O_busy), 64'd0);
    check("rst_done", 64'(O_done), 64'd0);
    check("rst_addr", 64'(O_ram_addr), 64'd0);
    check("rst_stall", 64'(O_stall_cnt), 64'd0);
    @(negedge I_clk);
    I_rst_n = 1'b1;

    run_job(10'd0, 11'd4, 0, 0);
    post_job(4, 1);
    check("t1_first_valid", 64'(first_v), 64'd2);
    check("t1_last_cyc", 64'(last_cyc), 64'd5);
    check("t1_done_cyc", 64'(done_cyc), 64'd6);

    run_job(10'd1022, 11'd4, 0, 0);
    post_job(4, 1);
    check("t2_done_cyc", 64'(done_cyc), 64'd6);

    run_job(10'd0, 11'd8, 1, 0);
    post_job(8, 1);
`ifdef IBUF_RD_STALL_CNT_EN
    check("t3_stall7", 64'(O_stall_cnt), 64'd7);
`endif

    run_job(10'd3, 11'd0, 0, 0);
    check("t4_done_cyc", 64'(done_cyc), 64'd1);
    check("t4_valid_never", 64'(first_v), 64'hFFFF_FFFF_FFFF_FFFF);
    check("t4_busy_never", 64'(busy_seen), 64'd0);
    check("t4_done_cnt", 64'(done_cnt), 64'd1);

    run_job(10'd5, 11'd6, 0, 1);
    post_job(6, 1);
    check("t5_done_cyc", 64'(done_cyc), 64'd8);

    load_expect(10'd100, 11'd16);
    clear_stats();
    tick(1'b1, 1'b1, 10'd100, 11'd16);
    for (int k = 0; k < 20 && beats < 2; k++) tick(1'b1, 1'b0, 10'd100, 11'd16);
    check("t6_beats_pre", 64'(beats), 64'd2);
    @(negedge I_clk);
    I_rst_n = 1'b0;
    #1;
    check("t6_valid", 64'(strm.valid), 64'd0);
    check("t6_data", 64'(strm.data), 64'd0);
    check("t6_busy", 64'(O_busy), 64'd0);
    check("t6_done", 64'(O_done), 64'd0);
    check("t6_addr", 64'(O_ram_addr), 64'd0);
    check("t6_stall", 64'(O_stall_cnt), 64'd0);
    done_cnt = 0; busy_seen = 0; prev_stall = 0;
    repeat (2) tick(1'b1, 1'b0, 10'd100, 11'd16);
    @(negedge I_clk);
    I_rst_n = 1'b1;
    repeat (6) tick(1'b1, 1'b0, 10'd100, 11'd16);
    check("t6_no_done", 64'(done_cnt), 64'd0);
    check("t6_no_busy", 64'(busy_seen), 64'd0);
    check("t6_beats_post", 64'(beats), 64'd2);

    run_job(10'd7, 11'd2, 0, 0);
    post_job(2, 1);
    check("t7_done_cyc", 64'(done_cyc), 64'd4);

    run_job(10'd50, 11'd3, 3, 0);
    post_job(3, 1);
    check("t8_addr_adv", 64'(max_off <= 2), 64'd1);

    for (int j = 0; j < 6; j++) begin
      rb = ASIZE'($urandom);
      rl = (ASIZE + 1)'($urandom_range(1, 40));
      run_job(rb, rl, 2, 0);
      post_job(int'(rl), 1);
    end

    check("ram_wr_never", 64'(wr_seen), 64'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
